// File: rtl/bf_core_if.sv
`default_nettype none
// ============================================================================
// Module   : bf_core_if
// Brief    : Instruction fetch and byte-stream handshake bundle for bf_core.
// Revision : 1.0
// ============================================================================
interface bf_core_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 12
);
    logic [PC_W-1:0]   imem_addr;
    logic [3:0]        imem_data;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output imem_addr,
        input  imem_data,
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/bf_core.sv
`default_nettype none
// ============================================================================
// Module   : bf_core
// Brief    : Brainfuck interpreter core, one instruction per cycle, tape in regs.
// Revision : 1.0
// ============================================================================
module bf_core #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 10,
    parameter int PC_W       = 12,
    parameter int LOOP_DEPTH = 16
) (
    input  wire logic clk,
    input  wire logic reset,
    bf_core_if.master bus,
    output logic      done,
    output logic      error
);
    localparam int SP_W  = $clog2(LOOP_DEPTH + 1);
    localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

    localparam logic [3:0] c_OP_INC   = 4'd0;
    localparam logic [3:0] c_OP_DEC   = 4'd1;
    localparam logic [3:0] c_OP_RIGHT = 4'd2;
    localparam logic [3:0] c_OP_LEFT  = 4'd3;
    localparam logic [3:0] c_OP_OPEN  = 4'd4;
    localparam logic [3:0] c_OP_CLOSE = 4'd5;
    localparam logic [3:0] c_OP_OUT   = 4'd6;
    localparam logic [3:0] c_OP_IN    = 4'd7;
    localparam logic [3:0] c_OP_HALT  = 4'd15;

    typedef enum logic [2:0] {
        S_CLEAR    = 3'd0,
        S_RUN      = 3'd1,
        S_SKIP     = 3'd2,
        S_WAIT_IN  = 3'd3,
        S_WAIT_OUT = 3'd4,
        S_HALT     = 3'd5,
        S_ERROR    = 3'd6
    } state_t;

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [ADDR_W-1:0] head_q;
    logic [ADDR_W-1:0] clr_q;
    logic [SP_W-1:0]   sp_q;
    logic [PC_W-1:0]   skip_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              done_q;
    logic              error_q;

    logic [DATA_W-1:0] tape_q  [2**ADDR_W];
    logic [PC_W-1:0]   stack_q [LOOP_DEPTH];

    logic [DATA_W-1:0] w_cell;
    logic [PC_W-1:0]   w_pc_inc;
    logic [IDX_W-1:0]  w_push_idx;
    logic [IDX_W-1:0]  w_top_idx;
    logic              w_tape_we;
    logic [ADDR_W-1:0] w_tape_waddr;
    logic [DATA_W-1:0] w_tape_wdata;

    assign w_cell     = tape_q[head_q];
    assign w_pc_inc   = pc_q + PC_W'(1);
    assign w_push_idx = IDX_W'(sp_q);
    assign w_top_idx  = IDX_W'(sp_q - SP_W'(1));

    assign bus.imem_addr = pc_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign done          = done_q;
    assign error         = error_q;

    // Tape writes come from three sources: the clear sweep, +/- and accepted input.
    always_comb begin
        w_tape_we    = 1'b0;
        w_tape_waddr = head_q;
        w_tape_wdata = '0;
        if (reset) begin
            case (state_q)
                S_CLEAR: begin
                    w_tape_we    = 1'b1;
                    w_tape_waddr = clr_q;
                end
                S_RUN: begin
                    if (bus.imem_data == c_OP_INC) begin
                        w_tape_we    = 1'b1;
                        w_tape_wdata = w_cell + DATA_W'(1);
                    end else if (bus.imem_data == c_OP_DEC) begin
                        w_tape_we    = 1'b1;
                        w_tape_wdata = w_cell - DATA_W'(1);
                    end
                end
                S_WAIT_IN: begin
                    if (bus.in_valid) begin
                        w_tape_we    = 1'b1;
                        w_tape_wdata = bus.in_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_tape_we) begin
            tape_q[w_tape_waddr] <= w_tape_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_CLEAR;
            pc_q        <= '0;
            head_q      <= '0;
            clr_q       <= '0;
            sp_q        <= '0;
            skip_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    clr_q <= clr_q + ADDR_W'(1);
                    if (clr_q == {ADDR_W{1'b1}}) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    case (bus.imem_data)
                        c_OP_RIGHT: begin
                            head_q <= head_q + ADDR_W'(1);
                            pc_q   <= w_pc_inc;
                        end
                        c_OP_LEFT: begin
                            head_q <= head_q - ADDR_W'(1);
                            pc_q   <= w_pc_inc;
                        end
                        c_OP_OPEN: begin
                            if (w_cell == '0) begin
                                state_q <= S_SKIP;
                                skip_q  <= PC_W'(1);
                                pc_q    <= w_pc_inc;
                            end else if (sp_q == SP_W'(LOOP_DEPTH)) begin
                                state_q <= S_ERROR;
                                done_q  <= 1'b1;
                                error_q <= 1'b1;
                            end else begin
                                stack_q[w_push_idx] <= w_pc_inc;
                                sp_q                <= sp_q + SP_W'(1);
                                pc_q                <= w_pc_inc;
                            end
                        end
                        c_OP_CLOSE: begin
                            if (sp_q == '0) begin
                                state_q <= S_ERROR;
                                done_q  <= 1'b1;
                                error_q <= 1'b1;
                            end else if (w_cell != '0) begin
                                // Jump back to the body start; the entry stays for the next pass.
                                pc_q <= stack_q[w_top_idx];
                            end else begin
                                sp_q <= sp_q - SP_W'(1);
                                pc_q <= w_pc_inc;
                            end
                        end
                        c_OP_OUT: begin
                            state_q     <= S_WAIT_OUT;
                            out_valid_q <= 1'b1;
                            out_data_q  <= w_cell;
                        end
                        c_OP_IN: begin
                            state_q    <= S_WAIT_IN;
                            in_ready_q <= 1'b1;
                        end
                        c_OP_HALT: begin
                            state_q <= S_HALT;
                            done_q  <= 1'b1;
                        end
                        default: begin
                            pc_q <= w_pc_inc;
                        end
                    endcase
                end
                S_SKIP: begin
                    pc_q <= w_pc_inc;
                    if (bus.imem_data == c_OP_OPEN) begin
                        skip_q <= skip_q + PC_W'(1);
                    end else if (bus.imem_data == c_OP_CLOSE) begin
                        skip_q <= skip_q - PC_W'(1);
                        if (skip_q == PC_W'(1)) begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_WAIT_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        pc_q        <= w_pc_inc;
                        state_q     <= S_RUN;
                    end
                end
                S_WAIT_IN: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        pc_q       <= w_pc_inc;
                        state_q    <= S_RUN;
                    end
                end
                S_HALT, S_ERROR: ;
                default: begin
                    state_q <= S_ERROR;
                    done_q  <= 1'b1;
                    error_q <= 1'b1;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bf_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_bf_core
// Brief    : Self-checking bench for bf_core against a behavioural interpreter.
// Revision : 1.0
// ============================================================================
module tb_bf_core;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 4;
    localparam int PC_W       = 8;
    localparam int LOOP_DEPTH = 2;
    localparam int TAPE_N     = 1 << ADDR_W;
    localparam int PROG_N     = 1 << PC_W;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic done;
    logic error;

    bf_core_if #(.DATA_W(DATA_W), .PC_W(PC_W)) bus ();

    bf_core #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .LOOP_DEPTH(LOOP_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    logic [3:0] imem [PROG_N];
    assign bus.imem_data = imem[bus.imem_addr];

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] m_in [$];
    logic [DATA_W-1:0] m_out [$];
    logic [DATA_W-1:0] obs_out [$];
    bit m_done, m_err;
    int obs_first_out, obs_inrdy, obs_outv, obs_unstable;
    bit obs_done, obs_err, obs_timeout;
    logic [PC_W-1:0] obs_pc;

    task automatic load_prog(input string s);
        foreach (imem[i]) imem[i] = 4'd15;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "+": imem[i] = 4'd0;
                "-": imem[i] = 4'd1;
                ">": imem[i] = 4'd2;
                "<": imem[i] = 4'd3;
                "[": imem[i] = 4'd4;
                "]": imem[i] = 4'd5;
                ".": imem[i] = 4'd6;
                ",": imem[i] = 4'd7;
                "n": imem[i] = 4'(8 + (i % 7));
                default: imem[i] = 4'd15;
            endcase
        end
    endtask

    // Plain interpreter over the program text; no notion of cycles.
    task automatic model_run();
        logic [DATA_W-1:0] tape [TAPE_N];
        logic [ADDR_W-1:0] head;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   stk [$];
        logic [3:0]        op;
        int ip, steps, depth;
        m_out.delete();
        m_done = 0;
        m_err  = 0;
        foreach (tape[i]) tape[i] = '0;
        head = '0; pc = '0; ip = 0; steps = 0;
        while (!m_done && steps < 50000) begin
            op = imem[pc];
            steps++;
            case (op)
                4'd0: begin tape[head] = tape[head] + DATA_W'(1); pc++; end
                4'd1: begin tape[head] = tape[head] - DATA_W'(1); pc++; end
                4'd2: begin head++; pc++; end
                4'd3: begin head--; pc++; end
                4'd4: begin
                    if (tape[head] == '0) begin
                        depth = 1;
                        pc++;
                        while (depth > 0 && steps < 50000) begin
                            if (imem[pc] == 4'd4) depth++;
                            else if (imem[pc] == 4'd5) depth--;
                            pc++;
                            steps++;
                        end
                    end else if (stk.size() >= LOOP_DEPTH) begin
                        m_done = 1; m_err = 1;
                    end else begin
                        stk.push_back(pc + PC_W'(1));
                        pc++;
                    end
                end
                4'd5: begin
                    if (stk.size() == 0) begin
                        m_done = 1; m_err = 1;
                    end else if (tape[head] != '0) begin
                        pc = stk[$];
                    end else begin
                        void'(stk.pop_back());
                        pc++;
                    end
                end
                4'd6: begin m_out.push_back(tape[head]); pc++; end
                4'd7: begin
                    tape[head] = (ip < m_in.size()) ? m_in[ip] : '0;
                    ip++;
                    pc++;
                end
                4'd15: m_done = 1;
                default: pc++;
            endcase
        end
    endtask

    // Resets the core, runs the loaded program and records what it does.
    // Negative delays select random handshake timing.
    task automatic run_prog(input int in_dly, input int out_dly, input int budget);
        int cyc, ip, in_wait, out_wait;
        bit give, prev_hold;
        logic [DATA_W-1:0] prev_data;
        obs_out.delete();
        obs_first_out = -1; obs_inrdy = 0; obs_outv = 0; obs_unstable = 0;
        @(negedge clk);
        reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cyc = 0; ip = 0; in_wait = 0; out_wait = 0; prev_hold = 0; prev_data = '0;
        while (!done && cyc < budget) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (prev_hold && (!bus.out_valid || bus.out_data !== prev_data)) obs_unstable++;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            bus.in_data   = DATA_W'($urandom);
            if (bus.out_valid) begin
                obs_outv++;
                if (obs_first_out < 0) obs_first_out = cyc;
                give = (out_dly < 0) ? ($urandom_range(0, 1) == 1) : (out_wait >= out_dly);
                out_wait++;
                if (give) begin
                    bus.out_ready = 1'b1;
                    obs_out.push_back(bus.out_data);
                    out_wait = 0;
                end
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            if (bus.in_ready) begin
                obs_inrdy++;
                give = (in_dly < 0) ? ($urandom_range(0, 1) == 1) : (in_wait >= in_dly);
                in_wait++;
                if (give) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = (ip < m_in.size()) ? m_in[ip] : '0;
                    ip++;
                    in_wait = 0;
                end
            end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        obs_done = done; obs_err = error; obs_pc = bus.imem_addr; obs_timeout = !done;
    endtask

    task automatic test_reset();
        load_prog("+++.H");
        reset = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_data = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %0h expected 0", bus.out_data); end
        n_checks++; if (bus.imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %0h expected 0", bus.imem_addr); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    endtask

    task automatic test_basic();
        load_prog("+++.H");
        m_in.delete();
        run_prog(0, 0, 2000);
        n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL basic_timeout: got no done expected done"); end
        n_checks++; if (obs_first_out != 20) begin n_fail++; $display("FAIL basic_latency: got %0d expected 20", obs_first_out); end
        n_checks++; if (obs_out.size() != 1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", obs_out.size()); end
        else begin
            n_checks++; if (obs_out[0] !== 8'd3) begin n_fail++; $display("FAIL basic_data: got %0h expected 3", obs_out[0]); end
        end
        n_checks++; if (obs_done !== 1'b1 || obs_err !== 1'b0) begin n_fail++; $display("FAIL basic_status: got done=%b err=%b expected done=1 err=0", obs_done, obs_err); end
        n_checks++; if (obs_pc !== 8'd4) begin n_fail++; $display("FAIL basic_halt_pc: got %0d expected 4", obs_pc); end
    endtask

    task automatic test_wrap();
        string progs [2];
        logic [DATA_W-1:0] exp [2];
        progs[0] = "-.H";    exp[0] = 8'd255;
        progs[1] = "<+><.H"; exp[1] = 8'd1;
        for (int t = 0; t < 2; t++) begin
            load_prog(progs[t]);
            run_prog(0, 0, 2000);
            n_checks++;
            if (obs_out.size() != 1 || obs_out[0] !== exp[t]) begin
                n_fail++;
                $display("FAIL wrap%0d: got count=%0d data=%0h expected count=1 data=%0h", t, obs_out.size(),
                         (obs_out.size() > 0) ? obs_out[0] : 8'h00, exp[t]);
            end
        end
    endtask

    task automatic test_loop();
        load_prog("++[->+++<]>.H");
        run_prog(0, 0, 2000);
        n_checks++;
        if (obs_out.size() != 1 || obs_out[0] !== 8'd6) begin
            n_fail++;
            $display("FAIL loop_data: got count=%0d data=%0h expected count=1 data=6", obs_out.size(),
                     (obs_out.size() > 0) ? obs_out[0] : 8'h00);
        end
        n_checks++; if (obs_first_out != 35) begin n_fail++; $display("FAIL loop_latency: got %0d expected 35", obs_first_out); end
        n_checks++; if (obs_err !== 1'b0) begin n_fail++; $display("FAIL loop_error: got %b expected 0", obs_err); end
    endtask

    task automatic test_skip();
        // The trailing ']' faults only if the skipped brackets never touched the stack.
        load_prog("[+[+]+]+.]H");
        run_prog(0, 0, 2000);
        n_checks++;
        if (obs_out.size() != 1 || obs_out[0] !== 8'd1) begin
            n_fail++;
            $display("FAIL skip_data: got count=%0d data=%0h expected count=1 data=1", obs_out.size(),
                     (obs_out.size() > 0) ? obs_out[0] : 8'h00);
        end
        n_checks++; if (obs_first_out != 25) begin n_fail++; $display("FAIL skip_latency: got %0d expected 25", obs_first_out); end
        n_checks++; if (obs_err !== 1'b1 || obs_done !== 1'b1) begin n_fail++; $display("FAIL skip_stack: got done=%b err=%b expected 1 1", obs_done, obs_err); end
    endtask

    task automatic test_stack_err();
        load_prog("+[[[H");
        run_prog(0, 0, 2000);
        n_checks++; if (obs_err !== 1'b1 || obs_done !== 1'b1) begin n_fail++; $display("FAIL overflow: got done=%b err=%b expected 1 1", obs_done, obs_err); end
        load_prog("+[[H");
        run_prog(0, 0, 2000);
        n_checks++; if (obs_err !== 1'b0 || obs_done !== 1'b1) begin n_fail++; $display("FAIL depth_ok: got done=%b err=%b expected 1 0", obs_done, obs_err); end
        load_prog("]H");
        run_prog(0, 0, 2000);
        n_checks++; if (obs_err !== 1'b1 || obs_done !== 1'b1) begin n_fail++; $display("FAIL underflow: got done=%b err=%b expected 1 1", obs_done, obs_err); end
    endtask

    task automatic test_handshake();
        load_prog(",.H");
        m_in.delete();
        m_in.push_back(8'h41);
        run_prog(5, 3, 2000);
        n_checks++; if (obs_inrdy != 6) begin n_fail++; $display("FAIL in_ready_cycles: got %0d expected 6", obs_inrdy); end
        n_checks++; if (obs_outv != 4) begin n_fail++; $display("FAIL out_valid_cycles: got %0d expected 4", obs_outv); end
        n_checks++; if (obs_unstable != 0) begin n_fail++; $display("FAIL out_stable: got %0d changes expected 0", obs_unstable); end
        n_checks++;
        if (obs_out.size() != 1 || obs_out[0] !== 8'h41) begin
            n_fail++;
            $display("FAIL in_to_out: got count=%0d data=%0h expected count=1 data=41", obs_out.size(),
                     (obs_out.size() > 0) ? obs_out[0] : 8'h00);
        end
    endtask

    task automatic test_reset_wait_out();
        int cyc;
        bit stable;
        load_prog("+.H");
        @(negedge clk);
        reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            cyc = 0;
            while (!bus.out_valid && cyc < 100) begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
            end
            n_checks++; if (cyc != 18) begin n_fail++; $display("FAIL wo_latency%0d: got %0d expected 18", pass, cyc); end
            n_checks++; if (bus.out_data !== 8'd1) begin n_fail++; $display("FAIL wo_data%0d: got %0h expected 1", pass, bus.out_data); end
            stable = 1;
            repeat (3) begin
                @(negedge clk);
                if (!bus.out_valid || bus.out_data !== 8'd1) stable = 0;
            end
            n_checks++; if (!stable) begin n_fail++; $display("FAIL wo_hold%0d: got unstable expected held", pass); end
            reset = 1'b0;
            @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL wo_abort%0d: got %b expected 0", pass, bus.out_valid); end
            reset = 1'b1;
        end
    endtask

    task automatic test_random();
        string prog, tok;
        int ntok;
        for (int p = 0; p < 10; p++) begin
            prog = "";
            ntok = $urandom_range(6, 20);
            for (int t = 0; t < ntok; t++) begin
                case ($urandom_range(0, 11))
                    0: tok = "+";
                    1: tok = "-";
                    2: tok = ">";
                    3: tok = "<";
                    4: tok = ".";
                    5: tok = ",";
                    6: tok = "n";
                    7: tok = "[-]";
                    8: tok = "[>[-]<-]";
                    9: tok = "+++[-.]";
                    10: tok = "[+]";
                    default: tok = ($urandom_range(0, 9) == 0) ? "]" : ">>";
                endcase
                prog = {prog, tok};
            end
            prog = {prog, "H"};
            load_prog(prog);
            m_in.delete();
            for (int k = 0; k < 32; k++) m_in.push_back(DATA_W'($urandom));
            model_run();
            run_prog(-1, -1, 20000);
            n_checks++; if (obs_timeout) begin n_fail++; $display("FAIL rand%0d_timeout: got no done expected done", p); end
            n_checks++; if (obs_out.size() != m_out.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d expected %0d", p, obs_out.size(), m_out.size()); end
            for (int k = 0; k < m_out.size() && k < obs_out.size(); k++) begin
                n_checks++;
                if (obs_out[k] !== m_out[k]) begin n_fail++; $display("FAIL rand%0d_out%0d: got %0h expected %0h", p, k, obs_out[k], m_out[k]); end
            end
            n_checks++;
            if (obs_done !== m_done || obs_err !== m_err) begin
                n_fail++;
                $display("FAIL rand%0d_status: got done=%b err=%b expected done=%b err=%b", p, obs_done, obs_err, m_done, m_err);
            end
            n_checks++; if (obs_unstable != 0) begin n_fail++; $display("FAIL rand%0d_stable: got %0d changes expected 0", p, obs_unstable); end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_loop();
        test_skip();
        test_stack_err();
        test_handshake();
        test_reset_wait_out();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
